ps2_host_tx: RTL
================

PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, 5000, clock-low hold before start bit (100 us at 50 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, 1000000, max cycles between device clock falling edges (20 ms at 50 MHz).
REQ-003 clock  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 tx_valid  input  1  request to send tx_data.
REQ-006 tx_data  input  8  command byte to the keyboard (e.g. 0xED set-LEDs).
REQ-007 tx_ready  output  1  high only in IDLE; the byte is accepted when tx_valid & tx_ready.
REQ-008 ps2_clk_in / ps2_data_in  input  1 each  raw pad reads of ps2_clock / ps2_data.
REQ-009 ps2_clk_oe / ps2_data_oe  output  1 each  1 = pull line low; 0 = release (the top level drives 0 or Z).
REQ-010 tx_busy  output  1  high from acceptance until return to IDLE; used by the top level to gate the PS/2 receiver.
REQ-011 tx_done  output  1  one-cycle pulse on successful completion.
REQ-012 tx_error  output  1  one-cycle pulse on timeout or missing ACK.

Function
REQ-013 Both pad inputs SHALL pass a 2-flop synchronizer; a falling edge SHALL be detected one cycle after the synchronized value goes from 1 to 0.
REQ-014 The FSM SHALL have the states IDLE, INHIBIT, START, SHIFT, ACK and WAIT_IDLE.
REQ-015 IDLE: on acceptance, latch tx_data, compute odd parity (~^tx_data), and enter INHIBIT.
REQ-016 INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_CYCLES cycles; in the last cycle assert ps2_data_oe=1 (start bit), then go to START.
REQ-017 START: release clk_oe and keep data_oe=1 until the first device falling edge, then go to SHIFT.
REQ-018 SHIFT: on each falling edge k=1..10 drive the next bit (data_oe = ~bit): bits 1-8 are data LSB first, bit 9 is parity, bit 10 is stop (released). After edge 10 go to ACK.
REQ-019 ACK: on the next falling edge sample ps2_data; 0 = ACK, 1 = NACK. Go to WAIT_IDLE.
REQ-020 WAIT_IDLE: when both synchronized lines read 1, pulse tx_done (ACK) or tx_error (NACK) and return to IDLE.
REQ-021 A 20-bit watchdog SHALL clear on every falling edge and on entering START; if it reaches TIMEOUT_CYCLES in START, SHIFT or ACK, release both lines, pulse tx_error, and go to IDLE.
REQ-022 tx_valid while not in IDLE SHALL be ignored; no queuing.
REQ-023 tx_done and tx_error SHALL never assert in the same cycle.
REQ-024 Pad outputs SHALL be registered (no combinational glitch).

Reset
REQ-025 On reset the FSM goes to IDLE, and clk_oe=0, data_oe=0, tx_busy=0, tx_done=0, tx_error=0, tx_ready=1, counters=0.
REQ-026 Reset mid-transfer SHALL release both lines on the next clock edge; no done or error pulse.

Configuration
REQ-027 Macro PS2_TX_ACK_CHECK_EN: when defined, a NACK at REQ-019 yields tx_error.
REQ-028 Without PS2_TX_ACK_CHECK_EN the ACK bit is sampled but ignored, and every untimed-out transfer ends in tx_done.

Structure
REQ-029 Package ps2_pkg SHALL hold the FSM state encoding, the default INHIBIT/TIMEOUT constants, and the command constants (0xED, 0xF4, 0xFF).
REQ-030 Sub-module ps2_line_sync (2-flop synchronizer plus falling-edge detect) SHALL be instantiated twice; it is reusable by the receiver.

Verification
REQ-031 Send 0xED with a device model that ACKs -> serialized bits 1,0,1,1,0,1,1,1, parity 1, stop 1; tx_done pulse once; tx_busy low after.
REQ-032 Send 0xF4 -> bits 0,0,1,0,1,1,1,1, parity 0; clk_oe low for exactly 5000 cycles before release.
REQ-033 Device model stops clocking after edge 4 -> tx_error exactly 1000000 cycles after the last edge; both oe=0; tx_ready=1.
REQ-034 Device NACKs (data=1 at edge 11) -> tx_error with the macro; tx_done without it.
REQ-035 Assert reset during SHIFT edge 6 -> next cycle clk_oe=0, data_oe=0, no pulses; a following send of 0xFF completes normally.
REQ-036 tx_valid held high throughout the 0xED transfer with tx_data changed to 0x00 -> the serialized byte stays 0xED and a second transfer starts only after return to IDLE.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-TX state encoding, default timing constants,
// common keyboard command bytes and the frame parity helper.
package ps2_pkg;

  typedef logic [7:0] ps2_byte_t;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INHIBIT   = 3'd1;
  localparam logic [2:0] ST_START     = 3'd2;
  localparam logic [2:0] ST_SHIFT     = 3'd3;
  localparam logic [2:0] ST_ACK       = 3'd4;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

  // 100 us inhibit and 20 ms inter-edge watchdog at 50 MHz
  localparam int unsigned INHIBIT_CYCLES_DEFAULT = 5000;
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1000000;

  localparam ps2_byte_t CMD_SET_LEDS = 8'hED;
  localparam ps2_byte_t CMD_ENABLE   = 8'hF4;
  localparam ps2_byte_t CMD_RESET    = 8'hFF;

  function automatic logic odd_parity(input ps2_byte_t b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Byte-request handshake and status between the command issuer and the PS/2 host transmitter.
interface ps2_host_tx_if;
  import ps2_pkg::*;

  logic      tx_valid;
  ps2_byte_t tx_data;
  logic      tx_ready;
  logic      tx_busy;
  logic      tx_done;
  logic      tx_error;

  modport master (output tx_valid, tx_data, input tx_ready, tx_busy, tx_done, tx_error);
  modport slave  (input tx_valid, tx_data, output tx_ready, tx_busy, tx_done, tx_error);

endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one PS/2 pad with falling-edge detect; idle (high) after reset.
module ps2_line_sync (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic sync,
  output logic fall
);

  logic meta;
  logic prev;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= raw;
      sync <= meta;
      prev <= sync;
    end
  end

  assign fall = prev & ~sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter (inhibit, start, 8 data, odd parity, stop, ACK).
// Define PS2_TX_ACK_CHECK_EN to turn a device NACK into tx_error instead of tx_done.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = INHIBIT_CYCLES_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic         clock,
  input  logic         reset,
  ps2_host_tx_if.slave tx,
  input  logic         ps2_clk_in,
  input  logic         ps2_data_in,
  output logic         ps2_clk_oe,
  output logic         ps2_data_oe
);

`ifdef PS2_TX_ACK_CHECK_EN
  localparam logic ACK_CHECK = 1'b1;
`else
  localparam logic ACK_CHECK = 1'b0;
`endif

  localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [19:0]      TO_LAST  = 20'(TIMEOUT_CYCLES - 1);

  logic [2:0]       state;
  logic [INH_W-1:0] inhibit_cnt;
  logic [19:0]      wdog;
  logic [9:0]       shift;
  logic [3:0]       edge_cnt;
  logic             nack;
  logic             clk_oe;
  logic             data_oe;
  logic             done;
  logic             error;

  logic clk_sync;
  logic clk_fall;
  logic data_sync;
  logic data_fall_unused;
  logic watching;
  logic timeout;

  ps2_line_sync u_clk_sync (
    .clock (clock),
    .reset (reset),
    .raw   (ps2_clk_in),
    .sync  (clk_sync),
    .fall  (clk_fall)
  );

  ps2_line_sync u_data_sync (
    .clock (clock),
    .reset (reset),
    .raw   (ps2_data_in),
    .sync  (data_sync),
    .fall  (data_fall_unused)
  );

  assign watching = (state == ST_START) || (state == ST_SHIFT) || (state == ST_ACK);
  assign timeout  = watching && !clk_fall && (wdog == TO_LAST);

  // Held at zero outside the device-clocked states, so it is already clear on entering START.
  always_ff @(posedge clock) begin
    if (reset) begin
      wdog <= '0;
    end else if (!watching || clk_fall) begin
      wdog <= '0;
    end else begin
      wdog <= wdog + 20'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      clk_oe      <= 1'b0;
      data_oe     <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      inhibit_cnt <= '0;
      edge_cnt    <= '0;
      shift       <= '0;
      nack        <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      if (timeout) begin
        clk_oe  <= 1'b0;
        data_oe <= 1'b0;
        error   <= 1'b1;
        state   <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (tx.tx_valid) begin
              shift       <= {1'b1, odd_parity(tx.tx_data), tx.tx_data};
              inhibit_cnt <= '0;
              edge_cnt    <= '0;
              clk_oe      <= 1'b1;
              data_oe     <= (INHIBIT_CYCLES == 1);
              state       <= ST_INHIBIT;
            end
          end
          ST_INHIBIT: begin
            if (inhibit_cnt == INH_LAST) begin
              clk_oe <= 1'b0;
              state  <= ST_START;
            end else begin
              inhibit_cnt <= inhibit_cnt + INH_W'(1);
              // start bit goes low during the final inhibit cycle
              if (inhibit_cnt + INH_W'(1) == INH_LAST) begin
                data_oe <= 1'b1;
              end
            end
          end
          ST_START: begin
            if (clk_fall) begin
              data_oe  <= ~shift[0];
              shift    <= shift >> 1;
              edge_cnt <= 4'd1;
              state    <= ST_SHIFT;
            end
          end
          ST_SHIFT: begin
            if (clk_fall) begin
              data_oe  <= ~shift[0];
              shift    <= shift >> 1;
              edge_cnt <= edge_cnt + 4'd1;
              if (edge_cnt == 4'd9) begin
                state <= ST_ACK;
              end
            end
          end
          ST_ACK: begin
            if (clk_fall) begin
              nack  <= data_sync;
              state <= ST_WAIT_IDLE;
            end
          end
          ST_WAIT_IDLE: begin
            if (clk_sync && data_sync) begin
              error <= ACK_CHECK && nack;
              done  <= !(ACK_CHECK && nack);
              state <= ST_IDLE;
            end
          end
          default: begin
            clk_oe  <= 1'b0;
            data_oe <= 1'b0;
            state   <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign ps2_clk_oe  = clk_oe;
  assign ps2_data_oe = data_oe;

  assign tx.tx_ready = (state == ST_IDLE);
  assign tx.tx_busy  = (state != ST_IDLE);
  assign tx.tx_done  = done;
  assign tx.tx_error = error;

endmodule
